// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory
// responder (slave). Signal names follow the pipeline's bus naming.
interface dmem_responder_if;
   logic        i_DMR_req;
   logic        i_DMR_we;
   logic        i_DMR_byte;
   logic [31:0] i_DMR_addr;
   logic [31:0] i_DMR_wdata;
   logic        o_DMR_ready;
   logic        o_DMR_stall;
   logic        o_DMR_rvalid;
   logic [31:0] o_DMR_rdata;
   logic        o_DMR_err;

   modport master (
      output i_DMR_req, i_DMR_we, i_DMR_byte, i_DMR_addr, i_DMR_wdata,
      input  o_DMR_ready, o_DMR_stall, o_DMR_rvalid, o_DMR_rdata, o_DMR_err
   );

   modport slave (
      input  i_DMR_req, i_DMR_we, i_DMR_byte, i_DMR_addr, i_DMR_wdata,
      output o_DMR_ready, o_DMR_stall, o_DMR_rvalid, o_DMR_rdata, o_DMR_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store bus.
// One request at a time, WAIT_CYC wait states, one-cycle response pulse.
// Optional macro DMR_ALIGN_CHECK_EN: flag misaligned word accesses with err
// (no write, rdata=0); when undefined, addr[1:0] is ignored for word accesses.
//
// state   | meaning
// IDLE    | ready for a request; stall follows req combinationally
// WAIT    | request captured, counting down wait states
// RESP    | access performed, rvalid pulse, pipeline released
module dmem_responder #(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 2
) (
   input logic             clk,
   input logic             rstn,
   dmem_responder_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

   state_t              stateQ, stateD;
   logic [3:0]          cntQ, cntD;
   logic                accept;
   logic                capWe, capByte;
   logic [ADDR_W+1:0]   capAddr;
   logic [31:0]         capWdata;
   logic [31:0]         rdataQ;
   logic [31:0]         mem [2**ADDR_W];
   logic [ADDR_W-1:0]   wordIdx;
   logic [1:0]          lane;
   logic [31:0]         memWord;
   logic [7:0]          selByte;
   logic                misaligned;
   logic [31:0]         loadResult;
   logic                respUpdates;
   logic                unusedAddrBits;

   assign unusedAddrBits = ^bus.i_DMR_addr[31:ADDR_W+2];

   assign wordIdx = capAddr[ADDR_W+1:2];
   assign lane    = capAddr[1:0];
   assign memWord = mem[wordIdx];
   assign selByte = memWord[8*lane +: 8];

`ifdef DMR_ALIGN_CHECK_EN
   assign misaligned = !capByte && (lane != 2'd0);
`else
   assign misaligned = 1'b0;
`endif

   // load data path: misaligned accesses return zero
   always_comb begin
      loadResult = memWord;
      if (misaligned)
         loadResult = 32'h0;
      else if (capByte)
         loadResult = {{24{selByte[7]}}, selByte};
   end

   // next-state and countdown
   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      accept = 1'b0;
      case (stateQ)
         ST_IDLE: begin
            if (bus.i_DMR_req) begin
               accept = 1'b1;
               if (WAIT_CYC == 0) begin
                  stateD = ST_RESP;
               end else begin
                  cntD   = WAIT_LD;
                  stateD = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cntD = cntQ - 4'd1;
            if (cntQ == 4'd1) stateD = ST_RESP;
         end
         ST_RESP: stateD = ST_IDLE;
         default: stateD = ST_IDLE;
      endcase
   end

   // state register and countdown
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stateQ <= ST_IDLE;
         cntQ   <= 4'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   // capture request fields at acceptance; later input changes are ignored
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         capWe    <= 1'b0;
         capByte  <= 1'b0;
         capAddr  <= '0;
         capWdata <= 32'h0;
      end else if (accept) begin
         capWe    <= bus.i_DMR_we;
         capByte  <= bus.i_DMR_byte;
         capAddr  <= bus.i_DMR_addr[ADDR_W+1:0];
         capWdata <= bus.i_DMR_wdata;
      end
   end

   // loads (and flagged accesses) update rdata; stores leave it alone
   assign respUpdates = (stateQ == ST_RESP) && (!capWe || misaligned);

   // rdata holds between responses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rdataQ <= 32'h0;
      else if (respUpdates)
         rdataQ <= loadResult;
   end

   // store commits at the end of RESP; a reset before then drops it
   always_ff @(posedge clk) begin
      if (stateQ == ST_RESP && capWe && !misaligned) begin
         if (capByte)
            mem[wordIdx][8*lane +: 8] <= capWdata[7:0];
         else
            mem[wordIdx] <= capWdata;
      end
   end

   assign bus.o_DMR_ready  = rstn && (stateQ == ST_IDLE);
   assign bus.o_DMR_stall  = rstn && (((stateQ == ST_IDLE) && bus.i_DMR_req) ||
                                      (stateQ == ST_WAIT));
   assign bus.o_DMR_rvalid = (stateQ == ST_RESP);
   assign bus.o_DMR_rdata  = respUpdates ? loadResult : rdataQ;
   assign bus.o_DMR_err    = (stateQ == ST_RESP) && misaligned;

endmodule
